// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute-stage ALU feeding the EX/MEM pipeline register.
// Computes the result combinationally from the operation code and the two
// operands. It then captures the result, flags and destination control on
// the rising clock edge. A flush inserts a bubble, a stall holds the
// register, and a flush takes priority over a stall.
module alu_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             inValid,
  input  logic             regWriteIn,
  input  logic [4:0]       destRegIn,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegalOp,
  output logic             outValid,
  output logic             regWriteOut,
  output logic [4:0]       destRegOut
);

  localparam logic [2:0] OP_NOTHING = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_SUB     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_SLT     = 3'b101;

  // The pipeline register either holds a real instruction or a bubble.
  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_illegal;
  logic             w_zero;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;
  logic             r_reg_write;
  logic [4:0]       r_dest_reg;

  assign w_sum  = opA + opB;
  assign w_diff = opA - opB;
  // A direct signed compare does not depend on the sign of A-B.
  // A-B can overflow, so its sign alone would give the wrong answer.
  assign w_slt  = ($signed(opA) < $signed(opB));

  // ALU datapath: select the result and derive the overflow and illegal flags.
  always_comb begin
    // NOTE: every output of this block gets a default first.
    // Then no path through the case statement can leave it unassigned,
    // so no latch is inferred.
    w_result   = '0;
    w_overflow = 1'b0;
    w_illegal  = 1'b0;
    case (operation)
      OP_NOTHING: w_result = '0;
      OP_ADD: begin
        w_result   = w_sum;
        w_overflow = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND:  w_result = opA & opB;
      OP_OR:   w_result = opA | opB;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_zero = (w_result == '0);

  // State register: VALID/BUBBLE view of the pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments.
    // All registers then update together from pre-edge values.
    if (!rst_n) r_state <= ST_BUBBLE;
    else        r_state <= w_next_state;
  end

  // Next state: a flush always forces a bubble.
  // A stall holds the state; otherwise the register loads inValid.
  always_comb begin
    w_next_state = r_state;
    if (flush)       w_next_state = ST_BUBBLE;
    else if (!stall) w_next_state = inValid ? ST_VALID : ST_BUBBLE;
  end

  // Data and control fields of the EX/MEM register.
  // The priority is reset, then flush, then stall, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
      r_reg_write <= 1'b0;
      r_dest_reg  <= '0;
    end else if (flush) begin
      // result, zero and destination keep their values in a flushed slot.
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      // Bubble data fields are still captured.
      // Consumers qualify every field with outValid.
      r_result    <= w_result;
      r_zero      <= w_zero;
      r_overflow  <= w_overflow;
      r_illegal   <= w_illegal & inValid;
      r_reg_write <= regWriteIn & inValid;
      r_dest_reg  <= destRegIn;
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_overflow;
  assign illegalOp   = r_illegal;
  assign outValid    = (r_state == ST_VALID);
  assign regWriteOut = r_reg_write;
  assign destRegOut  = r_dest_reg;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Testbench for alu_ex_stage.
// Directed and randomized stimulus is checked against an arithmetic
// reference model of the EX/MEM register.
module tb_alu_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  operation;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        inValid;
  logic        regWriteIn;
  logic [4:0]  destRegIn;
  logic        stall;
  logic        flush;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegalOp;
  logic        outValid;
  logic        regWriteOut;
  logic [4:0]  destRegOut;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the pipeline register.
  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic        vld;
    logic        rw;
    logic [4:0]  dst;
  } model_t;

  model_t m;

  alu_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .opA(opA), .opB(opB),
    .inValid(inValid), .regWriteIn(regWriteIn), .destRegIn(destRegIn),
    .stall(stall), .flush(flush), .result(result), .zero(zero),
    .overflow(overflow), .illegalOp(illegalOp), .outValid(outValid),
    .regWriteOut(regWriteOut), .destRegOut(destRegOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] got_vec();
    return {result, zero, overflow, illegalOp, outValid, regWriteOut, destRegOut};
  endfunction

  function automatic logic [41:0] exp_vec();
    return {m.res, m.zero, m.ovf, m.ill, m.vld, m.rw, m.dst};
  endfunction

  task automatic model_reset();
    m.res = '0; m.zero = 1'b1; m.ovf = 1'b0; m.ill = 1'b0;
    m.vld = 1'b0; m.rw = 1'b0; m.dst = '0;
  endtask

  // Behavioural model of one clock edge.
  // The math uses wide signed integers.
  task automatic model_edge();
    longint sa, sb, s;
    logic [31:0] r;
    logic ov, il;
    sa = longint'(int'(opA));
    sb = longint'(int'(opB));
    r = '0; ov = 1'b0; il = 1'b0;
    case (operation)
      3'd1: begin s = sa + sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: begin s = sa - sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd3: r = opA & opB;
      3'd4: r = opA | opB;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6, 3'd7: il = 1'b1;
      default: r = '0;
    endcase
    if (flush) begin
      m.vld = 1'b0; m.rw = 1'b0; m.ill = 1'b0; m.ovf = 1'b0;
    end else if (!stall) begin
      m.res = r; m.zero = (r == 0); m.ovf = ov; m.ill = il & inValid;
      m.vld = inValid; m.rw = regWriteIn & inValid; m.dst = destRegIn;
    end
  endtask

  // Drive one cycle of inputs, clock them in, update the model.
  // Then step 1 time unit past the edge.
  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic v, input logic rw, input logic [4:0] d,
                      input logic st, input logic fl);
    operation = op; opA = a; opB = b; inValid = v; regWriteIn = rw;
    destRegIn = d; stall = st; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    // Check the power-on reset values, then drive a valid load.
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_initial got=%h exp=%h", got_vec(), exp_vec());
    end
    rst_n = 1'b1;
    step(3'd1, 32'd3, 32'd4, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    n_checks++;
    if (outValid !== 1'b1 || result !== 32'd7) begin
      n_fail++; $display("FAIL reset_preload got=%0d/%h exp=1/00000007", outValid, result);
    end
    // Assert reset mid-cycle; it must take effect without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (got_vec() !== exp_vec() || zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_async got=%h exp=%h", got_vec(), exp_vec());
    end
    #1 rst_n = 1'b1;
    step(3'd3, 32'hF0, 32'h3C, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0);
    n_checks++;
    if (got_vec() !== exp_vec() || result !== 32'h30) begin
      n_fail++; $display("FAIL reset_first_load got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_add_overflow();
    step(3'd1, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'h80000000 || overflow !== 1'b1 || zero !== 1'b0 || outValid !== 1'b1) begin
      n_fail++; $display("FAIL add_overflow got=%h ov=%0d z=%0d v=%0d exp=80000000 1 0 1",
                         result, overflow, zero, outValid);
    end
  endtask

  task automatic test_sub_slt();
    step(3'd2, 32'd5, 32'd5, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_equal got=%h z=%0d ov=%0d exp=0 1 0", result, zero, overflow);
    end
    step(3'd5, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'd1) begin
      n_fail++; $display("FAIL slt_neg got=%h exp=00000001", result);
    end
    step(3'd5, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL slt_ovf_range got=%h ov=%0d exp=0 0", result, overflow);
    end
    step(3'd2, 32'h80000000, 32'd1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sub_overflow got=%h ov=%0d exp=7fffffff 1", result, overflow);
    end
  endtask

  task automatic test_stall();
    step(3'd3, 32'hF0F0, 32'hFF00, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'hF000) begin
      n_fail++; $display("FAIL stall_load got=%h exp=0000f000", result);
    end
    for (int i = 0; i < 3; i++) begin
      step(3'($urandom_range(1, 5)), $urandom, $urandom, 1'b1, 1'b0, 5'($urandom), 1'b1, 1'b0);
      n_checks++;
      if (result !== 32'hF000 || got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_hold cycle=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    step(3'd4, 32'h1, 32'h100, 1'b1, 1'b0, 5'd11, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'h101 || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stall_release got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] prev;
    step(3'd1, 32'd100, 32'd23, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    prev = m.res;
    step(3'd4, 32'hAAAA, 32'h5555, 1'b1, 1'b1, 5'd13, 1'b1, 1'b1);
    n_checks++;
    if (outValid !== 1'b0 || regWriteOut !== 1'b0 || result !== prev || destRegOut !== 5'd12) begin
      n_fail++; $display("FAIL flush_stall got=v%0d rw%0d %h d%0d exp=v0 rw0 %h d12",
                         outValid, regWriteOut, result, destRegOut, prev);
    end
    step(3'd1, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 5'd14, 1'b0, 1'b1);
    n_checks++;
    if (outValid !== 1'b0 || result !== prev || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL flush_drop got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_illegal();
    step(3'd7, $urandom, $urandom, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0);
    n_checks++;
    if (result !== 32'd0 || illegalOp !== 1'b1 || zero !== 1'b1) begin
      n_fail++; $display("FAIL illegal_valid got=%h ill=%0d exp=0 1", result, illegalOp);
    end
    step(3'd7, $urandom, $urandom, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
    n_checks++;
    if (illegalOp !== 1'b0 || regWriteOut !== 1'b0 || outValid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_bubble got=ill%0d rw%0d v%0d exp=0 0 0",
                         illegalOp, regWriteOut, outValid);
    end
  endtask

  task automatic test_back_to_back();
    // Randomized traffic mixes operations, bubbles, stalls and flushes.
    // Special operand values are included.
    logic [31:0] pick [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      step(3'($urandom), a, b, ($urandom_range(0, 4) != 0), 1'($urandom), 5'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; operation = '0; opA = '0; opB = '0; inValid = 1'b0;
    regWriteIn = 1'b0; destRegIn = '0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #12;
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_stall();
    test_flush_stall();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage ALU with registered EX/MEM output, placed directly downstream of the ALU controller. Consumes the 3-bit operation code and the two operands, computes the result combinationally, and captures result, flags and destination control into the EX/MEM pipeline register. Supports pipeline stall (hold) and flush (bubble insertion), and has one cycle of latency.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- operation  input  3  ALU operation code: 000 NOTHING, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT (signed); 110/111 are illegal
- opA  input  WIDTH  operand A (rs or forwarded value)
- opB  input  WIDTH  operand B (rt or sign-extended immediate)
- inValid  input  1  the EX instruction is real (not a bubble)
- regWriteIn  input  1  the instruction writes the register file
- destRegIn  input  5  destination register number
- stall  input  1  hold all output registers
- flush  input  1  replace the captured instruction with a bubble
- result  output  WIDTH  registered ALU result
- zero  output  1  registered (result == 0)
- overflow  output  1  registered signed overflow (ADD/SUB only)
- illegalOp  output  1  registered: the captured valid instruction had operation 110/111
- outValid  output  1  registered valid
- regWriteOut  output  1  registered regWriteIn, gated by validity
- destRegOut  output  5  registered destRegIn

## Operation
- Combinational compute, all modulo 2^WIDTH:
  - ADD: A+B
  - SUB: A−B
  - AND: A&B
  - OR: A|B
  - SLT: {WIDTH−1 zeros, signed(A)<signed(B)}
  - NOTHING: 0
  - 110/111: 0, with illegalOp asserted
- SLT compares signed values and must be correct when A−B overflows (e.g. A=0x7FFFFFFF, B=0x80000000 gives 0).
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other operations: 0.
- zero is computed from the combinational result before the register.
- Register update priority per rising edge: reset > flush > stall > load.
  - load: all outputs capture their next values. outValid ← inValid. regWriteOut ← regWriteIn & inValid. illegalOp ← illegal code & inValid.
  - stall only: every output holds its value.
  - flush (with or without stall): outValid, regWriteOut, illegalOp and overflow go to 0. result, zero and destRegOut hold their values.
- Data fields for a bubble (inValid=0) are still computed and captured. Consumers must qualify every field with outValid.
- The state of the block is the single pipeline register (two states: VALID/BUBBLE via outValid).
  - BUBBLE→VALID on load with inValid=1.
  - VALID→BUBBLE on load with inValid=0, or on flush.
  - Any state holds on stall without flush.

## Timing
- Latency: inputs sampled at edge N appear on the outputs after edge N; throughput is 1 per cycle when not stalled.
- Reset (rst_n low, asynchronous, takes effect immediately without a clock):
  - result=0, zero=1, overflow=0, illegalOp=0, outValid=0, regWriteOut=0, destRegOut=0.
  - Deasserting reset mid-stream: the first edge with rst_n high performs a normal load.
- Outputs change only on clk edges or on rst_n assertion. No output has a combinational path from the inputs.
- stall may stay asserted for any number of cycles; the outputs stay constant throughout.
- A flush on the same edge as new valid input drops that input.

## Test plan
- Reset: assert rst_n=0 mid-cycle with outValid=1 -> all outputs go to their reset values immediately (zero=1), with no clock edge.
- ADD overflow: op=001, A=0x7FFFFFFF, B=0x00000001, inValid=1 -> next edge result=0x80000000, overflow=1, zero=0, outValid=1.
- SUB/SLT: SUB with A=5, B=5 -> result=0, zero=1. SLT with A=0xFFFFFFFF, B=1 -> result=1. SLT with A=0x7FFFFFFF, B=0x80000000 -> result=0, overflow=0.
- Stall: load AND of 0xF0F0 and 0xFF00 -> 0xF000, then stall=1 for 3 cycles with new inputs -> outputs stay at 0xF000 for all 3 cycles, then update on the first edge after stall drops.
- Flush vs stall: stall=1 and flush=1 with regWriteIn=1 -> outValid=0, regWriteOut=0, result unchanged.
- Illegal/bubble: op=111 with inValid=1 -> result=0, illegalOp=1. op=111 with inValid=0 -> illegalOp=0, regWriteOut=0 even if regWriteIn=1.
